// File: rtl/read_master_burst_hdmi.sv
// Avalon-MM burst read master that streams one video frame (or repeats it)
// from memory into a downstream FIFO, never requesting more than the FIFO can
// hold and never keeping more than MAX_PENDING bursts in flight.
//
// Avalon read handshake: oRead, oRead_address and oBurstcount form one request
// and stay frozen while iWait_request is high. The request is accepted on the
// first clock edge where oRead=1 and iWait_request=0. iRd_Data_valid returns
// one beat per cycle and cannot be back-pressured.
module read_master_burst_hdmi #(
  parameter int ADDR_W      = 32,
  parameter int DATA_BYTES  = 4,
  parameter int BURST_LEN   = 8,
  parameter int MAX_PENDING = 2
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic              iStop,
  input  logic              iLoop,
  input  logic [ADDR_W-1:0] iStart_read_address,
  input  logic [ADDR_W-1:0] iLength,
  input  logic              iWait_request,
  input  logic              iRd_Data_valid,
  input  logic [15:0]       iFF_space,
  output logic              oRead,
  output logic [ADDR_W-1:0] oRead_address,
  output logic [6:0]        oBurstcount,
  output logic              oBusy,
  output logic              oFrame_start,
  output logic              oDone
);

  localparam int OFFS = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_DRAIN} state_t;

  state_t            state, state_next;

  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length_words;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] words_left;
  logic              loop_mode;
  logic              stop_flag;
  logic              settled;
  logic [6:0]        burst_q;
  logic [15:0]       pending_words;
  logic [3:0]        pending_bursts;

  // Sizes of accepted-but-unreturned bursts, oldest at rd_ptr. Eight slots
  // cover every legal MAX_PENDING, so the 3-bit pointers wrap naturally.
  logic [6:0]        burst_fifo [8];
  logic [2:0]        wr_ptr, rd_ptr;
  logic [6:0]        head_beats;

  logic [6:0]        burst_min;
  logic              beat, head_done, stop_pending, space_ok;
  logic [15:0]       pending_after;
  logic              start, issue, accept, finish, restart, frame_end;

  // Burst size for the next request and the per-cycle bookkeeping terms.
  always_comb begin
    if (words_left < ADDR_W'(BURST_LEN)) burst_min = words_left[6:0];
    else                                 burst_min = 7'(BURST_LEN);
    // A beat with nothing outstanding is stray and must not wrap the counter.
    beat          = iRd_Data_valid && (pending_words != 16'd0);
    head_done     = beat && ((head_beats + 7'd1) == burst_fifo[rd_ptr]);
    pending_after = pending_words - 16'(beat);
    stop_pending  = stop_flag | iStop;
    space_ok      = (17'(pending_words) + 17'(burst_q)) <= 17'(iFF_space);
  end

  // FSM state register.
  always_ff @(posedge iClk) begin
    if (!iReset_n) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    issue      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    restart    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart) begin
          start      = 1'b1;
          state_next = S_ARB;
        end
      end
      S_ARB: begin
        if ((words_left == '0) || stop_pending) begin
          if (pending_after == 16'd0) frame_end = 1'b1;
          else                        state_next = S_DRAIN;
        end else if (settled && (pending_bursts < 4'(MAX_PENDING)) && space_ok) begin
          // settled: burst_q was registered from words_left one cycle ago,
          // so the space comparison starts from registered values.
          issue      = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (!iWait_request) begin
          accept     = 1'b1;
          state_next = S_ARB;
        end
      end
      S_DRAIN: begin
        if (pending_after == 16'd0) frame_end = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // A frame has fully returned: either replay it or report completion.
    if (frame_end) begin
      if (loop_mode && !stop_pending && (length_words != '0)) begin
        restart    = 1'b1;
        state_next = S_ARB;
      end else begin
        finish     = 1'b1;
        state_next = S_IDLE;
      end
    end
  end

  // Frame address/length tracking, outstanding-beat counters and outputs.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      base_addr      <= '0;
      length_words   <= '0;
      addr           <= '0;
      words_left     <= '0;
      loop_mode      <= 1'b0;
      stop_flag      <= 1'b0;
      settled        <= 1'b0;
      burst_q        <= 7'd0;
      pending_words  <= 16'd0;
      pending_bursts <= 4'd0;
      wr_ptr         <= 3'd0;
      rd_ptr         <= 3'd0;
      head_beats     <= 7'd0;
      oRead          <= 1'b0;
      oRead_address  <= '0;
      oBurstcount    <= 7'd0;
      oBusy          <= 1'b0;
      oFrame_start   <= 1'b0;
      oDone          <= 1'b0;
    end else begin
      if (start) begin
        base_addr    <= iStart_read_address;
        addr         <= iStart_read_address;
        length_words <= iLength >> OFFS;
        words_left   <= iLength >> OFFS;
        loop_mode    <= iLoop;
      end else if (restart) begin
        addr         <= base_addr;
        words_left   <= length_words;
      end else if (accept) begin
        addr         <= addr + (ADDR_W'(burst_q) << OFFS);
        words_left   <= words_left - ADDR_W'(burst_q);
      end

      // Stop is sticky for the rest of the run and meaningless while idle.
      if ((state == S_IDLE) || (state_next == S_IDLE)) stop_flag <= 1'b0;
      else                                             stop_flag <= stop_flag | iStop;

      settled <= (state == S_ARB) && (state_next == S_ARB) && !restart;
      if (state == S_ARB) burst_q <= burst_min;

      // Acceptance and a returning beat may coincide; both apply.
      pending_words  <= pending_words + (accept ? 16'(burst_q) : 16'd0) - 16'(beat);
      pending_bursts <= pending_bursts + 4'(accept) - 4'(head_done);
      if (accept) wr_ptr <= wr_ptr + 3'd1;
      if (head_done) begin
        rd_ptr     <= rd_ptr + 3'd1;
        head_beats <= 7'd0;
      end else if (beat) begin
        head_beats <= head_beats + 7'd1;
      end

      if (issue) begin
        oRead         <= 1'b1;
        oRead_address <= addr;
        oBurstcount   <= burst_q;
      end else if (accept) begin
        oRead         <= 1'b0;
      end
      oBusy        <= (state_next != S_IDLE);
      oFrame_start <= start | restart;
      oDone        <= finish;
    end
  end

  // Burst-size record for each accepted request; data only, no reset needed.
  always_ff @(posedge iClk) begin
    if (accept) burst_fifo[wr_ptr] <= burst_q;
  end

endmodule
